// File: rtl/hls4ml_div_pkg.sv
// Shared definitions for the hls4ml sequential signed divider.
// - Default operand widths (23-bit signed dividend, 14-bit signed divisor).
// - FSM state encoding as plain localparam constants.
// - abs_u: signed value to unsigned magnitude. The most negative value maps to
//   2^(W-1), which still fits a W-bit unsigned result.
package hls4ml_div_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 23;
  localparam int unsigned DIVISOR_W_DEF  = 14;

  typedef logic [2:0] div_state_t;

  localparam div_state_t IDLE = 3'd0;
  localparam div_state_t PREP = 3'd1;
  localparam div_state_t ITER = 3'd2;
  localparam div_state_t FIX  = 3'd3;
  localparam div_state_t DONE = 3'd4;

  // Callers sign-extend into 32 bits and size-cast the result back down.
  function automatic logic [31:0] abs_u(input logic signed [31:0] v);
    return v[31] ? unsigned'(-v) : unsigned'(v);
  endfunction

endpackage

// File: rtl/hls4ml_div_step.sv
// One radix-2 restoring division step, purely combinational.
// Ports:
//   rem_i  : partial remainder (DsrW+1 bits)
//   dbit_i : next dividend bit, MSB first
//   dsr_i  : divisor magnitude (DsrW bits, unsigned)
//   rem_o  : next partial remainder
//   qbit_o : quotient bit (1 when the trial subtraction does not go negative)
module hls4ml_div_step #(
  parameter int unsigned DsrW = 14
) (
  input  logic [DsrW:0]   rem_i,
  input  logic            dbit_i,
  input  logic [DsrW-1:0] dsr_i,
  output logic [DsrW:0]   rem_o,
  output logic            qbit_o
);

  localparam int unsigned RemW = DsrW + 1;
  localparam int unsigned ShW  = RemW + 1;

  // Carry the full shifted value so the compare never loses the top bit.
  logic [ShW-1:0] shifted;
  logic [ShW-1:0] dsr_ext;

  assign shifted = {rem_i, dbit_i};
  assign dsr_ext = ShW'(dsr_i);

  assign qbit_o = (shifted >= dsr_ext);
  assign rem_o  = qbit_o ? RemW'(shifted - dsr_ext) : shifted[RemW-1:0];

endmodule

// File: rtl/hls4ml_seq_div_23s_14s.sv
// Sequential signed divider: quotient = dividend / divisor, truncated toward
// zero; remainder takes the sign of the dividend (or is 0). One restoring
// iteration per cycle, one operation in flight.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   ce                    : clock enable; 0 freezes all state and both handshakes
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE with ce=1)
//   dividend, divisor     : signed operands, captured on the input handshake
//   out_valid / out_ready : result handshake; result held until accepted
//   quotient, remainder   : signed results
// Optional macro HLS_DIV_STATUS_EN adds div_by_zero and div_overflow outputs,
// registered alongside the quotient.
// Sequence: IDLE -> PREP -> ITER (DIVIDEND_W cycles) -> FIX -> DONE -> IDLE,
// so out_valid rises DIVIDEND_W+2 cycles after the input handshake.
module hls4ml_seq_div_23s_14s
  import hls4ml_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DIVIDEND_W-1:0] quotient,
  output logic signed [DIVISOR_W-1:0]  remainder
`ifdef HLS_DIV_STATUS_EN
  ,
  output logic                         div_by_zero,
  output logic                         div_overflow
`endif
);

  localparam int unsigned RemW = DIVISOR_W + 1;
  localparam int unsigned CntW = $clog2(DIVIDEND_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DIVIDEND_W - 1);

  div_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Raw operands captured at the handshake so the inputs may change freely.
  logic signed [DIVIDEND_W-1:0] dvd_raw_q, dvd_raw_d;
  logic signed [DIVISOR_W-1:0]  dsr_raw_q, dsr_raw_d;

  logic dvd_neg_q, dvd_neg_d;
  logic dsr_neg_q, dsr_neg_d;

  // Dividend magnitude doubles as a shift register feeding bits MSB first.
  logic [DIVIDEND_W-1:0] dvd_abs_q, dvd_abs_d;
  logic [DIVISOR_W-1:0]  dsr_abs_q, dsr_abs_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;

  logic signed [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic signed [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                         out_valid_q, out_valid_d;

`ifdef HLS_DIV_STATUS_EN
  logic dz_q, dz_d;
  logic ovf_q, ovf_d;
`endif

  logic [RemW-1:0] step_rem;
  logic            step_qbit;

  hls4ml_div_step #(
    .DsrW(DIVISOR_W)
  ) u_step (
    .rem_i (rem_q),
    .dbit_i(dvd_abs_q[DIVIDEND_W-1]),
    .dsr_i (dsr_abs_q),
    .rem_o (step_rem),
    .qbit_o(step_qbit)
  );

  assign in_ready  = (state_q == IDLE) & ce;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef HLS_DIV_STATUS_EN
  assign div_by_zero  = dz_q;
  assign div_overflow = ovf_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_raw_d   = dvd_raw_q;
    dsr_raw_d   = dsr_raw_q;
    dvd_neg_d   = dvd_neg_q;
    dsr_neg_d   = dsr_neg_q;
    dvd_abs_d   = dvd_abs_q;
    dsr_abs_d   = dsr_abs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = out_valid_q;
`ifdef HLS_DIV_STATUS_EN
    dz_d        = dz_q;
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_raw_d = dividend;
          dsr_raw_d = divisor;
          state_d   = PREP;
        end
      end

      PREP: begin
        dvd_neg_d = dvd_raw_q[DIVIDEND_W-1];
        dsr_neg_d = dsr_raw_q[DIVISOR_W-1];
        dvd_abs_d = DIVIDEND_W'(abs_u(32'(dvd_raw_q)));
        dsr_abs_d = DIVISOR_W'(abs_u(32'(dsr_raw_q)));
        rem_d     = '0;
        quo_d     = '0;
        cnt_d     = CntLast;
        state_d   = ITER;
      end

      ITER: begin
        rem_d     = step_rem;
        quo_d     = {quo_q[DIVIDEND_W-2:0], step_qbit};
        dvd_abs_d = {dvd_abs_q[DIVIDEND_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      FIX: begin
        // A zero divisor lets every trial subtraction succeed; override the
        // result explicitly rather than trusting the iteration output.
        if (dsr_abs_q == '0) begin
          quotient_d  = '1;
          remainder_d = '0;
        end else begin
          // Most-negative / -1: the magnitude 2^(W-1) reinterpreted as signed
          // is already the saturated answer, and no negation is applied.
          quotient_d  = (dvd_neg_q ^ dsr_neg_q) ? -quo_q : quo_q;
          remainder_d = dvd_neg_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
        end
`ifdef HLS_DIV_STATUS_EN
        dz_d  = (dsr_raw_q == '0);
        ovf_d = (dvd_raw_q == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (dsr_raw_q == '1);
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_raw_q   <= '0;
      dsr_raw_q   <= '0;
      dvd_neg_q   <= 1'b0;
      dsr_neg_q   <= 1'b0;
      dvd_abs_q   <= '0;
      dsr_abs_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
`ifdef HLS_DIV_STATUS_EN
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_raw_q   <= dvd_raw_d;
      dsr_raw_q   <= dsr_raw_d;
      dvd_neg_q   <= dvd_neg_d;
      dsr_neg_q   <= dsr_neg_d;
      dvd_abs_q   <= dvd_abs_d;
      dsr_abs_q   <= dsr_abs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
`ifdef HLS_DIV_STATUS_EN
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_hls4ml_seq_div_23s_14s.sv
// Bench for hls4ml_seq_div_23s_14s: directed vector table, protocol corner
// cases (back-pressure, ce stall, mid-operation reset) and random operands
// checked against an arithmetic reference model.
module tb_hls4ml_seq_div_23s_14s;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [22:0] dividend = '0;
  logic signed [13:0] divisor = '0;
  logic in_ready;
  logic out_valid;
  logic signed [22:0] quotient;
  logic signed [13:0] remainder;
`ifdef HLS_DIV_STATUS_EN
  logic div_by_zero;
  logic div_overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hls4ml_seq_div_23s_14s dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder)
`ifdef HLS_DIV_STATUS_EN
    ,
    .div_by_zero (div_by_zero),
    .div_overflow(div_overflow)
`endif
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dz;
    bit ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer division semantics plus the two special cases.
  function automatic void model(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = -1;
      r = 0;
    end else if (a == -4194304 && b == -1) begin
      q = -4194304;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  int g_q, g_r, g_lat, g_dz, g_ovf;

  // One full transaction; stall_at>0 drops ce for 3 cycles, hold>0 applies
  // back-pressure in DONE for that many cycles.
  task automatic run_op(input int a, input int b, input int stall_at, input int hold,
                        input string tag);
    logic signed [22:0] ta;
    logic signed [13:0] tb_d;
    int exp_lat;
    ta = 23'(a);
    tb_d = 14'(b);
    exp_lat = (stall_at > 0) ? 28 : 25;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, int'(in_ready), 1);
    dividend = ta;
    divisor  = tb_d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 23'($urandom);
    divisor  = 14'($urandom);
    g_lat = 0;
    while (!out_valid && g_lat < 200) begin
      @(posedge clk);
      g_lat++;
      #1;
      if (g_lat == 5) chk({tag, "_busy_in_ready"}, int'(in_ready), 0);
      if (stall_at > 0 && g_lat == stall_at) ce = 1'b0;
      if (stall_at > 0 && g_lat == stall_at + 3) ce = 1'b1;
    end
    ce = 1'b1;
    chk({tag, "_latency"}, g_lat, exp_lat);
    g_q = int'(quotient);
    g_r = int'(remainder);
`ifdef HLS_DIV_STATUS_EN
    g_dz  = int'(div_by_zero);
    g_ovf = int'(div_overflow);
`else
    g_dz  = 0;
    g_ovf = 0;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_q"}, int'(quotient), g_q);
      chk({tag, "_hold_r"}, int'(remainder), g_r);
      chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  vec_t vecs[$];

  initial begin
    int eq, er, seen;
    vecs.push_back('{a: 100,      b: 7,     q: 14,       r: 2,    dz: 0, ovf: 0});
    vecs.push_back('{a: -100,     b: 7,     q: -14,      r: -2,   dz: 0, ovf: 0});
    vecs.push_back('{a: 100,      b: -7,    q: -14,      r: 2,    dz: 0, ovf: 0});
    vecs.push_back('{a: -100,     b: -7,    q: 14,       r: -2,   dz: 0, ovf: 0});
    vecs.push_back('{a: 5,        b: 0,     q: -1,       r: 0,    dz: 1, ovf: 0});
    vecs.push_back('{a: -4194304, b: -1,    q: -4194304, r: 0,    dz: 0, ovf: 1});
    vecs.push_back('{a: 4194303,  b: -8192, q: -511,     r: 8191, dz: 0, ovf: 0});
    vecs.push_back('{a: -4194304, b: -8192, q: 512,      r: 0,    dz: 0, ovf: 0});
    vecs.push_back('{a: 0,        b: 5,     q: 0,        r: 0,    dz: 0, ovf: 0});
    vecs.push_back('{a: -1,       b: 8191,  q: 0,        r: -1,   dz: 0, ovf: 0});

    // Reset state, with ce low so in_ready must stay low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_in_ready_ce0", int'(in_ready), 0);
`ifdef HLS_DIV_STATUS_EN
    chk("rst_div_by_zero", int'(div_by_zero), 0);
    chk("rst_div_overflow", int'(div_overflow), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    ce = 1'b1;
    #1;
    chk("rst_in_ready_ce1", int'(in_ready), 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_q", i), g_q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), g_r, vecs[i].r);
`ifdef HLS_DIV_STATUS_EN
      chk($sformatf("vec%0d_dz", i), g_dz, int'(vecs[i].dz));
      chk($sformatf("vec%0d_ovf", i), g_ovf, int'(vecs[i].ovf));
`endif
    end

    // Back-pressure: 5 cycles with out_ready low.
    run_op(-100, 7, 0, 5, "bp");
    chk("bp_q", g_q, -14);
    chk("bp_r", g_r, -2);

    // ce stall mid-ITER: latency +3, result unchanged.
    run_op(100, 7, 10, 0, "stall");
    chk("stall_q", g_q, 14);
    chk("stall_r", g_r, 2);

    // Reset pulse mid-ITER aborts the operation.
    @(negedge clk);
    dividend = 23'sd777;
    divisor  = 14'sd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_op(1000, 3, 0, 0, "fresh");
    chk("fresh_q", g_q, 333);
    chk("fresh_r", g_r, 1);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic signed [22:0] ra;
      logic signed [13:0] rb;
      ra = 23'($urandom);
      rb = 14'($urandom);
      if (i % 8 == 0) rb = '0;
      else if (i % 3 == 0) rb = 14'($signed($urandom_range(0, 15)) - 8);
      if (i % 5 == 0) ra = 23'($signed($urandom_range(0, 255)) - 128);
      model(int'(ra), int'(rb), eq, er);
      run_op(int'(ra), int'(rb), 0, 0, $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_q(%0d/%0d)", i, ra, rb), g_q, eq);
      chk($sformatf("rnd%0d_r(%0d/%0d)", i, ra, rb), g_r, er);
`ifdef HLS_DIV_STATUS_EN
      chk($sformatf("rnd%0d_dz", i), g_dz, (rb == 0) ? 1 : 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
